// File: rtl/param_sync_fifo.sv
// Parameterised single-clock FIFO with first-word-fall-through output, level flags and sticky error flags.
// Optional build macro PARAM_SYNC_FIFO_OVERWRITE_EN: a write while full replaces the oldest entry instead of being dropped.
module param_sync_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned AF_LEVEL   = DEPTH - 1,
  parameter int unsigned AE_LEVEL   = 1
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         clr,
  input  logic [DATA_WIDTH-1:0]        din,
  input  logic                         wr,
  input  logic                         rd,
  output logic [DATA_WIDTH-1:0]        dout,
  output logic                         full,
  output logic                         empty,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;

  logic push;
  logic pop;
  logic ovw;
  logic ovf_evt;
  logic unf_evt;

  always_comb begin
    full         = (count == CW'(DEPTH));
    empty        = (count == '0);
    almost_full  = (32'(count) >= AF_LEVEL);
    almost_empty = (32'(count) <= AE_LEVEL);
    dout         = empty ? '0 : mem[rd_ptr];
  end

  always_comb begin
    ovw     = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    ovf_evt = 1'b0;
    unf_evt = 1'b0;
    if (!clr) begin
`ifdef PARAM_SYNC_FIFO_OVERWRITE_EN
      ovw     = wr && full && !rd;
`else
      ovw     = 1'b0;
`endif
      // A full-overwrite is a push and pop together, so count holds at DEPTH.
      push    = (wr && (!full || rd)) || ovw;
      pop     = (rd && !empty) || ovw;
      ovf_evt = wr && full && !rd;
      unf_evt = rd && empty;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clr) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
      overflow  <= overflow  | ovf_evt;
      underflow <= underflow | unf_evt;
    end
  end

endmodule

// File: doc/param_sync_fifo.md
PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, payload width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, entry count; power of two, at least 2.
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-1, occupancy at or above which almost_full asserts.
REQ-004 SHALL have parameter AE_LEVEL, default 1, occupancy at or below which almost_empty asserts.
REQ-005 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port resetn, input, 1 bit; reset is asynchronous and active-low.
REQ-007 SHALL have port clr, input, 1 bit, synchronous flush.
REQ-008 SHALL have port din, input, DATA_WIDTH bits, write data.
REQ-009 SHALL have port wr, input, 1 bit, write request.
REQ-010 SHALL have port rd, input, 1 bit, read request (pop head).
REQ-011 SHALL have port dout, output, DATA_WIDTH bits, head entry (first-word-fall-through).
REQ-012 SHALL have port full, output, 1 bit, occupancy == DEPTH.
REQ-013 SHALL have port empty, output, 1 bit, occupancy == 0.
REQ-014 SHALL have port almost_full, output, 1 bit, occupancy >= AF_LEVEL.
REQ-015 SHALL have port almost_empty, output, 1 bit, occupancy <= AE_LEVEL.
REQ-016 SHALL have port count, output, $clog2(DEPTH+1) bits, current occupancy.
REQ-017 SHALL have port overflow, output, 1 bit, sticky flag for a rejected write.
REQ-018 SHALL have port underflow, output, 1 bit, sticky flag for a read while empty.

Function
REQ-019 SHALL store entries in a DEPTH-entry array with log2(DEPTH)-bit read/write pointers that wrap modulo DEPTH.
REQ-020 SHALL accept a write when wr=1 and (full=0 or rd=1): store din at wr_ptr, then increment wr_ptr.
REQ-021 SHALL accept a read when rd=1 and empty=0: increment rd_ptr.
REQ-022 SHALL update count as +1 for write only, -1 for read only, and unchanged for both or neither.
REQ-023 SHALL drive dout = mem[rd_ptr] combinationally when empty=0, and all-zero when empty=1.
REQ-024 SHALL make a word written into an empty FIFO visible on dout the cycle after the write edge (latency 1).
REQ-025 SHALL, on wr=1 and rd=1 while empty, accept the write, ignore the read, and set underflow.
REQ-026 SHALL, on wr=1 and rd=1 while full, accept both, leaving count = DEPTH and full = 1.
REQ-027 SHALL derive full, empty, almost_full and almost_empty combinationally from the count register.
REQ-028 SHALL, when clr=1, zero pointers, count, overflow and underflow at the next edge, ignoring wr/rd that cycle; memory contents are don't-care.
REQ-029 SHALL keep overflow and underflow set once set, until clr or reset.

Reset
REQ-030 SHALL, on resetn low, immediately clear pointers, count, overflow and underflow, without waiting for clk.
REQ-031 SHALL drive outputs during reset to empty=1, full=0, almost_empty=1, almost_full=0, count=0, dout=0.
REQ-032 SHALL discard any in-flight write when reset asserts mid-operation.
REQ-033 SHALL act on the first clk edge after resetn deasserts.

Configuration
REQ-034 SHALL support macro PARAM_SYNC_FIFO_OVERWRITE_EN.
REQ-035 SHALL, with the macro undefined, drop a write while full with rd=0 (no state change) and set overflow.
REQ-036 SHALL, with the macro defined, on a write while full with rd=0: overwrite the oldest entry, advance both pointers, hold count = DEPTH, and set overflow.

Verification
REQ-037 SHALL cover basic fill/drain: DEPTH=4, write 0x11,0x22,0x33,0x44 -> full=1, count=4, almost_full high from count=3; then read x4 -> dout 0x11,0x22,0x33,0x44 in order, empty=1.
REQ-038 SHALL cover pointer wrap: 10 interleaved write/read pairs with values 0x00..0x09 -> dout matches in order, count never exceeds 1, no flags set.
REQ-039 SHALL cover write when full: fill with 0xA0..0xA3, write 0xFF -> without macro, overflow=1 and drain yields A0..A3; with macro, overflow=1 and drain yields A1,A2,A3,FF.
REQ-040 SHALL cover simultaneous events: rd=1 and wr=1 with din=0x5A while empty -> underflow=1, count=1, dout=0x5A next cycle; same while full -> count stays 4, head advances.
REQ-041 SHALL cover reset/clear mid-operation: count=3, assert resetn low between clk edges -> outputs reset values immediately; repeat with clr=1 -> count=0 and flags cleared at the next edge.
